// File: rtl/fmult_seq.sv
// Time-multiplexed G.726 FMULT for the adaptive predictor.
// Ports: start latches b1..b6/dq1..dq6/a1,a2/sr1,sr2 and streams
// eight products (wout/widx/wlast) over wvalid/wready; busy in RUN,
// done pulses once after the last accept; scan ports are unused.
module fmult_seq #(
  parameter int NTAP_B = 6,
  parameter int NTAP_A = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] b1,
  input  logic [15:0] b2,
  input  logic [15:0] b3,
  input  logic [15:0] b4,
  input  logic [15:0] b5,
  input  logic [15:0] b6,
  input  logic [10:0] dq1,
  input  logic [10:0] dq2,
  input  logic [10:0] dq3,
  input  logic [10:0] dq4,
  input  logic [10:0] dq5,
  input  logic [10:0] dq6,
  input  logic [15:0] a1,
  input  logic [15:0] a2,
  input  logic [10:0] sr1,
  input  logic [10:0] sr2,
  input  logic        wready,
  output logic        wvalid,
  output logic [15:0] wout,
  output logic [2:0]  widx,
  output logic        wlast,
  output logic        busy,
  output logic        done,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4
);

  localparam int NTAP = NTAP_B + NTAP_A;
  localparam logic [2:0] LAST = 3'(NTAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_d;

  logic [15:0] coef_q [NTAP];
  logic [10:0] sig_q  [NTAP];

  logic load;
  logic step;
  logic is_last;

  logic [2:0]  nidx;
  logic [15:0] coef;
  logic [10:0] sig;

  logic        an_s;
  logic [12:0] an_mag;
  logic [3:0]  an_exp;
  logic [5:0]  an_mant;
  logic [18:0] an_sh;
  logic        w_s;
  logic [4:0]  w_exp;
  logic [7:0]  w_mant;
  logic [16:0] w_sh;
  logic [14:0] w_mag;
  logic [15:0] prod;

  logic unused_scan;

  assign unused_scan = ^{scan_in0, scan_in1, scan_in2,
                         scan_in3, scan_in4,
                         scan_enable, test_mode};

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  assign is_last = (widx == LAST);
  assign wvalid  = (state == RUN);
  assign busy    = (state == RUN);
  assign done    = (state == FIN);
  assign wlast   = wvalid && is_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (wready) begin
          if (is_last) begin
            state_d = FIN;
          end else begin
            step = 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tap 0 is computed straight from the ports on the start
  // cycle so the first product lands one cycle after start.
  always_comb begin
    nidx = widx + 3'd1;
    coef = coef_q[nidx];
    sig  = sig_q[nidx];
    if (state == IDLE) begin
      nidx = 3'd0;
      coef = b1;
      sig  = dq1;
    end
  end

  always_comb begin
    an_s   = coef[15];
    an_mag = an_s ? 13'((-coef) >> 2) : 13'(coef >> 2);
    an_exp = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (an_mag[i]) begin
        an_exp = 4'(i + 1);
      end
    end
    an_sh   = {an_mag, 6'b0};
    an_mant = (an_mag == 13'd0) ? 6'd32 : 6'(an_sh >> an_exp);
    w_s     = sig[10] ^ an_s;
    w_exp   = {1'b0, sig[9:6]} + {1'b0, an_exp};
    w_mant  = 8'(({6'b0, sig[5:0]} * {6'b0, an_mant}
                  + 12'd48) >> 4);
    w_sh    = {2'b0, w_mant, 7'b0};
    if (w_exp <= 5'd26) begin
      w_mag = 15'(w_sh >> (5'd26 - w_exp));
    end else begin
      w_mag = 15'(w_sh << (w_exp - 5'd26));
    end
    prod = w_s ? -{1'b0, w_mag} : {1'b0, w_mag};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      widx <= 3'd0;
      wout <= 16'd0;
      for (int i = 0; i < NTAP; i++) begin
        coef_q[i] <= 16'd0;
        sig_q[i]  <= 11'd0;
      end
    end else begin
      if (load) begin
        coef_q[0] <= b1;
        coef_q[1] <= b2;
        coef_q[2] <= b3;
        coef_q[3] <= b4;
        coef_q[4] <= b5;
        coef_q[5] <= b6;
        coef_q[6] <= a1;
        coef_q[7] <= a2;
        sig_q[0]  <= dq1;
        sig_q[1]  <= dq2;
        sig_q[2]  <= dq3;
        sig_q[3]  <= dq4;
        sig_q[4]  <= dq5;
        sig_q[5]  <= dq6;
        sig_q[6]  <= sr1;
        sig_q[7]  <= sr2;
      end
      if (load || step) begin
        widx <= nidx;
        wout <= prod;
      end
    end
  end

endmodule

// File: tb/tb_fmult_seq.sv
// Directed bench for fmult_seq.
// Hand-computed FMULT products, stalls, aborts and ignored starts.
module tb_fmult_seq;

  logic clk = 1'b0;
  logic reset, start, wready;
  logic [15:0] b1, b2, b3, b4, b5, b6, a1, a2;
  logic [10:0] dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2;
  logic wvalid, wlast, busy, done;
  logic [15:0] wout;
  logic [2:0] widx;
  logic so0, so1, so2, so3, so4;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_w [8];

  localparam logic [10:0] F_P9 = {1'b0, 4'd9, 6'd32};
  localparam logic [10:0] F_N9 = {1'b1, 4'd9, 6'd32};
  localparam logic [10:0] F_P15 = {1'b0, 4'd15, 6'd32};

  always #5 clk = ~clk;

  fmult_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6),
    .dq1(dq1), .dq2(dq2), .dq3(dq3),
    .dq4(dq4), .dq5(dq5), .dq6(dq6),
    .a1(a1), .a2(a2), .sr1(sr1), .sr2(sr2),
    .wready(wready), .wvalid(wvalid), .wout(wout),
    .widx(widx), .wlast(wlast), .busy(busy), .done(done),
    .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0),
    .scan_in3(1'b0), .scan_in4(1'b0),
    .scan_enable(1'b0), .test_mode(1'b0),
    .scan_out0(so0), .scan_out1(so1), .scan_out2(so2),
    .scan_out3(so3), .scan_out4(so4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ops;
    {b1, b2, b3, b4, b5, b6, a1, a2} = '0;
    {dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2} = '0;
    for (int i = 0; i < 8; i++) exp_w[i] = 16'h0000;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {wvalid, wlast, busy, done, widx, wout,
              so0, so1, so2, so3, so4}, 0);
  endtask

  task automatic run_seq(input bit stall);
    int got;
    int cyc;
    bit rdy;
    start = 1'b1;
    tick;
    start = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 200) begin
      rdy = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      chk("wvalid", wvalid, 1);
      chk("widx", widx, got);
      chk("wout", wout, exp_w[got]);
      chk("wlast", wlast, got == 7);
      chk("busy", busy, 1);
      chk("done_run", done, 0);
      if (stall && cyc == 2) begin
        start = 1'b1;
        b1 = 16'h1234;
        dq1 = 11'h7ff;
        a2 = 16'h7fff;
        sr2 = 11'h3ff;
      end
      wready = rdy;
      tick;
      start = 1'b0;
      if (rdy) got++;
      cyc++;
    end
    if (got < 8) chk("timeout", got, 8);
    wready = 1'b1;
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_valid", wvalid, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", wvalid, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    wready = 1'b1;
    clr_ops();
    tick;
    tick;
    chk_idle("rst_state");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk_idle("no_start");
    end

    reset = 1'b1;
    start = 1'b1;
    tick;
    reset = 1'b0;
    start = 1'b0;
    chk_idle("start_in_rst");
    tick;
    chk_idle("start_in_rst2");

    clr_ops();
    b1 = 16'h4000;
    dq1 = F_P9;
    exp_w[0] = 16'h0218;
    run_seq(1'b0);

    clr_ops();
    b1 = 16'hC000;
    dq1 = F_P9;
    a1 = 16'hC000;
    sr1 = F_N9;
    exp_w[0] = 16'hFDE8;
    exp_w[6] = 16'h0218;
    run_seq(1'b0);

    clr_ops();
    a2 = 16'h4000;
    sr2 = F_P15;
    exp_w[7] = 16'h0600;
    run_seq(1'b0);

    clr_ops();
    b1 = 16'h4000;
    dq1 = F_P9;
    b4 = 16'h2000;
    dq4 = F_P9;
    a1 = 16'hC000;
    sr1 = F_N9;
    a2 = 16'h4000;
    sr2 = F_P15;
    exp_w[0] = 16'h0218;
    exp_w[3] = 16'h010C;
    exp_w[6] = 16'h0218;
    exp_w[7] = 16'h0600;
    run_seq(1'b1);

    clr_ops();
    b1 = 16'h4000;
    dq1 = F_P9;
    b4 = 16'h2000;
    dq4 = F_P9;
    exp_w[0] = 16'h0218;
    exp_w[3] = 16'h010C;
    wready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    chk("abort_idx", widx, 3);
    chk("abort_wout", wout, exp_w[3]);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_valid", wvalid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick;
    chk("abort_nodone", done, 0);
    chk("abort_idle", busy, 0);
    run_seq(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
